param_fifo: RTL and testbench

- Parametrised synchronous FIFO; successor to the current flit/data FIFOs.
- Adds true full detection using an ADDR_WIDTH+1 count.
- Adds programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) mode, an occupancy output and sticky overflow/underflow flags.
- Protects its own state: illegal pushes and pops are ignored.
- Used as the buffer primitive in router input ports and core data queues.

---
 rtl/param_fifo_if.sv | 39 +++
 rtl/param_fifo.sv | 115 +++++++++++
 tb/tb_param_fifo.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : param_fifo_if
// Description : Push/pop handshake, status and error signals of param_fifo.
//               The master modport belongs to the user and the slave modport
//               to the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  full, almost_full, dout, dout_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output full, almost_full, dout, dout_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_fifo
// Description : Parametrised synchronous FIFO. It provides full detection
//               from a count one bit wider than the address, programmable
//               almost-full and almost-empty levels, an optional
//               first-word-fall-through output stage, and sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic        clk,
  input  logic        rst,
  param_fifo_if.slave bus
);

  localparam int                  c_DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_load;        // RAM read into the dout register this cycle
  logic w_valid_next;

  // Status flags are decoded from registered state only, so wr_en and rd_en
  // have no combinational path to them.
  assign w_full = (r_count == c_FULL_CNT);

  generate
    if (FWFT != 0) begin : g_fwft
      // count includes the word held in the output stage. The RAM therefore
      // holds count minus that word.
      logic [ADDR_WIDTH:0] w_ram_count;
      assign w_ram_count  = r_count - (ADDR_WIDTH+1)'(r_dout_valid);
      assign w_empty      = ~r_dout_valid;
      // Refill the output stage when it is empty or being popped, provided
      // the RAM holds a word written on an earlier edge.
      assign w_load       = (~r_dout_valid | w_pop) & (w_ram_count != '0);
      assign w_valid_next = w_load | (r_dout_valid & ~w_pop);
    end else begin : g_std
      assign w_empty      = (r_count == '0);
      assign w_load       = w_pop;
      assign w_valid_next = w_pop;
    end
  endgenerate

  assign w_push = bus.wr_en & ~w_full;
  assign w_pop  = bus.rd_en & ~w_empty;

  // Storage write port. Contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_load) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      r_dout_valid <= w_valid_next;
      // A new error in the same cycle as clr_err takes priority over the clear.
      r_overflow   <= (bus.wr_en & w_full)  | (r_overflow  & ~bus.clr_err);
      r_underflow  <= (bus.rd_en & w_empty) | (r_underflow & ~bus.clr_err);
    end
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (int'(r_count) >= AF_LEVEL);
  assign bus.almost_empty = (int'(r_count) <= AE_LEVEL);
  assign bus.count        = r_count;
  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_fifo
// Description : Directed self-checking bench for param_fifo. It covers one
//               standard-mode instance and one FWFT instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  param_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) s ();
  param_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) f ();

  param_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s.slave)
  );

  param_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s.wr_en = 1'b0; s.rd_en = 1'b0; s.din = '0; s.clr_err = 1'b0;
    f.wr_en = 1'b0; f.rd_en = 1'b0; f.din = '0; f.clr_err = 1'b0;
  endtask

  initial begin
    idle();
    #12;
    // Reset state
    check("rst_count",  32'(s.count), 0);
    check("rst_empty",  32'(s.empty), 1);
    check("rst_full",   32'(s.full), 0);
    check("rst_ae",     32'(s.almost_empty), 1);
    check("rst_af",     32'(s.almost_full), 0);
    check("rst_dout",   s.dout, 0);
    check("rst_valid",  32'(s.dout_valid), 0);
    check("rst_ovf",    32'(s.overflow), 0);
    check("rst_unf",    32'(s.underflow), 0);
    check("rst_f_empty", 32'(f.empty), 1);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0xA0..0xAF, watch almost_full edge at count 14
    for (int i = 0; i < 16; i++) begin
      s.wr_en = 1'b1; s.din = 32'hA0 + 32'(i);
      tick();
      check("fill_count", 32'(s.count), 32'(i + 1));
      check("fill_af",    32'(s.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(s.full), 1);
    s.din = 32'hFF;
    tick();
    check("ovf_set",   32'(s.overflow), 1);
    check("ovf_count", 32'(s.count), 16);
    s.wr_en = 1'b0; s.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_dout",  s.dout, 32'hA0 + 32'(i));
      check("drain_valid", 32'(s.dout_valid), 1);
      check("drain_ae",    32'(s.almost_empty), (15 - i <= 1) ? 32'd1 : 32'd0);
    end
    s.rd_en = 1'b0;
    tick();
    check("drain_empty",  32'(s.empty), 1);
    check("drain_vdrop",  32'(s.dout_valid), 0);
    check("drain_hold",   s.dout, 32'hAF);
    s.clr_err = 1'b1;
    tick();
    s.clr_err = 1'b0;
    check("ovf_clr", 32'(s.overflow), 0);

    // Standard-mode read latency and underflow
    s.wr_en = 1'b1; s.din = 32'h11;
    tick();
    s.wr_en = 1'b0;
    check("std_pre_valid", 32'(s.dout_valid), 0);
    s.rd_en = 1'b1;
    tick();
    check("std_dout",  s.dout, 32'h11);
    check("std_valid", 32'(s.dout_valid), 1);
    tick();
    s.rd_en = 1'b0;
    check("unf_set",   32'(s.underflow), 1);
    check("unf_dout",  s.dout, 32'h11);
    check("unf_valid", 32'(s.dout_valid), 0);
    s.clr_err = 1'b1;
    tick();
    s.clr_err = 1'b0;
    check("unf_clr", 32'(s.underflow), 0);

    // FWFT presentation and back-to-back pops
    f.wr_en = 1'b1; f.din = 32'h22;
    tick();
    check("fw_lat_valid", 32'(f.dout_valid), 0);
    check("fw_lat_count", 32'(f.count), 1);
    f.din = 32'h33;
    tick();
    check("fw_first_valid", 32'(f.dout_valid), 1);
    check("fw_first_dout",  f.dout, 32'h22);
    f.din = 32'h44;
    tick();
    check("fw_hold_dout",  f.dout, 32'h22);
    check("fw_hold_count", 32'(f.count), 3);
    f.wr_en = 1'b0; f.rd_en = 1'b1;
    tick();
    check("fw_pop1", f.dout, 32'h33);
    check("fw_pop1_valid", 32'(f.dout_valid), 1);
    tick();
    check("fw_pop2", f.dout, 32'h44);
    check("fw_pop2_valid", 32'(f.dout_valid), 1);
    tick();
    f.rd_en = 1'b0;
    check("fw_end_valid", 32'(f.dout_valid), 0);
    check("fw_end_count", 32'(f.count), 0);
    check("fw_end_empty", 32'(f.empty), 1);

    // Wrap: steady count of 5 with simultaneous push/pop
    for (int i = 0; i < 5; i++) begin
      s.wr_en = 1'b1; s.din = 32'h100 + 32'(i);
      tick();
    end
    s.rd_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      s.din = 32'h105 + 32'(j);
      tick();
      check("wrap_dout",  s.dout, 32'h100 + 32'(j));
      check("wrap_count", 32'(s.count), 5);
    end
    s.wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wrap_tail", s.dout, 32'h128 + 32'(k));
    end
    s.rd_en = 1'b0;
    check("wrap_empty", 32'(s.empty), 1);

    // Push while full with a simultaneous pop
    for (int i = 0; i < 16; i++) begin
      s.wr_en = 1'b1; s.din = 32'h200 + 32'(i);
      tick();
    end
    s.rd_en = 1'b1; s.din = 32'hFF;
    tick();
    s.wr_en = 1'b0; s.rd_en = 1'b0;
    check("fp_count", 32'(s.count), 15);
    check("fp_ovf",   32'(s.overflow), 1);
    check("fp_dout",  s.dout, 32'h200);
    s.clr_err = 1'b1;
    tick();
    check("fp_clr", 32'(s.overflow), 0);
    tick();
    s.clr_err = 1'b0;
    check("fp_clr_idle_ovf", 32'(s.overflow), 0);
    check("fp_clr_idle_unf", 32'(s.underflow), 0);

    // Mid-stream reset at count 7 with a flag set and dout_valid high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s.rd_en = 1'b1;
    tick();
    s.rd_en = 1'b0;
    check("mr_unf_pre", 32'(s.underflow), 1);
    for (int i = 0; i < 8; i++) begin
      s.wr_en = 1'b1; s.din = 32'h300 + 32'(i);
      tick();
    end
    s.wr_en = 1'b0; s.rd_en = 1'b1;
    tick();
    s.rd_en = 1'b0;
    check("mr_pre_count", 32'(s.count), 7);
    check("mr_pre_valid", 32'(s.dout_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_count", 32'(s.count), 0);
    check("mr_empty", 32'(s.empty), 1);
    check("mr_valid", 32'(s.dout_valid), 0);
    check("mr_unf",   32'(s.underflow), 0);
    check("mr_ovf",   32'(s.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    s.wr_en = 1'b1; s.din = 32'h55;
    tick();
    s.din = 32'h66;
    tick();
    s.wr_en = 1'b0; s.rd_en = 1'b1;
    tick();
    check("mr_first", s.dout, 32'h55);
    tick();
    s.rd_en = 1'b0;
    check("mr_second", s.dout, 32'h66);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
